risc_sequencer: RTL

Multi-cycle control unit for the non-pipelined 32-bit RISC core. It replaces free-running fetch/execute/write timing with an explicit state machine. The sequencer sequences instruction fetch, decode, execute, iterative rotate and result write-back, and shares the single-port memory between instruction and data accesses through a req/ack handshake. It drives only control strobes; PC, IR, register file, ALU and PSR stay in the datapath.

---
 rtl/risc_sequencer_if.sv | 34 +++
 rtl/risc_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/risc_sequencer_if.sv
// ============================================================================
// Module      : risc_sequencer_if
// Description : Memory request/acknowledge channel shared between the
//               sequencer (master) and the single-port memory (slave).
//               mem_req      - request, level, held until mem_ack
//               mem_we       - 1 = write, 0 = read; valid while mem_req
//               mem_addr_sel - 00 = pc, 01 = ir SRC field, 10 = ir DST field
//               mem_ack      - memory completed the current request
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface risc_sequencer_if;
   logic       mem_req;
   logic       mem_we;
   logic [1:0] mem_addr_sel;
   logic       mem_ack;

   modport master (
      output mem_req,
      output mem_we,
      output mem_addr_sel,
      input  mem_ack
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_addr_sel,
      output mem_ack
   );
endinterface

`default_nettype wire

// File: rtl/risc_sequencer.sv
// ============================================================================
// Module      : risc_sequencer
// Description : Multi-cycle control unit for the non-pipelined 32-bit RISC
//               core. Sequences fetch, decode, execute, iterative rotate and
//               write-back, and arbitrates the single-port memory between
//               instruction and data accesses. Drives control strobes only.
// Ports       : clk, reset        - clock, asynchronous active-high reset
//               run_i             - level, allows leaving IDLE
//               ir_i              - instruction register contents
//               cond_true_i       - branch condition from the datapath
//               rot_cnt_i         - signed rotate count (negative = left)
//               mem               - memory req/ack channel (master side)
//               ir_load_o, pc_inc_o, pc_load_o, alu_latch_o, rot_step_o,
//               rot_dir_o, rf_we_o, psr_upd_o - datapath strobes
//               halted_o          - HLT executed
//               illegal_o         - pulse on an undefined opcode
//               state_o           - current state, for debug
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module risc_sequencer #(
   parameter int ADDRSIZE = 12,
   parameter int WIDTH    = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                run_i,
   input  logic [WIDTH-1:0]    ir_i,
   input  logic                cond_true_i,
   input  logic [ADDRSIZE-1:0] rot_cnt_i,
   risc_sequencer_if.master    mem,
   output logic                ir_load_o,
   output logic                pc_inc_o,
   output logic                pc_load_o,
   output logic                alu_latch_o,
   output logic                rot_step_o,
   output logic                rot_dir_o,
   output logic                rf_we_o,
   output logic                psr_upd_o,
   output logic                halted_o,
   output logic                illegal_o,
   output logic [2:0]          state_o
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEMOP  = 3'd4,
      S_ROTATE = 3'd5,
      S_WRITE  = 3'd6,
      S_HALT   = 3'd7
   } state_t;

   localparam logic [3:0] OP_NOP = 4'b0000;
   localparam logic [3:0] OP_BRA = 4'b0001;
   localparam logic [3:0] OP_LD  = 4'b0010;
   localparam logic [3:0] OP_STR = 4'b0011;
   localparam logic [3:0] OP_ADD = 4'b0100;
   localparam logic [3:0] OP_MUL = 4'b0101;
   localparam logic [3:0] OP_CMP = 4'b0110;
   localparam logic [3:0] OP_SHF = 4'b0111;
   localparam logic [3:0] OP_ROT = 4'b1000;
   localparam logic [3:0] OP_HLT = 4'b1001;

   localparam logic [1:0] SEL_PC  = 2'b00;
   localparam logic [1:0] SEL_SRC = 2'b01;
   localparam logic [1:0] SEL_DST = 2'b10;

   state_t              state_q;
   logic                mem_req_q;
   logic                mem_we_q;
   logic [1:0]          mem_addr_sel_q;
   logic [ADDRSIZE-1:0] rot_cnt_q;
   logic                rot_dir_q;
   logic                halted_q;

   logic [3:0]          opcode;
   logic                ld_imm;
   logic                wr_to_mem;
   logic [ADDRSIZE-1:0] rot_mag;
   logic                unused_ir_bits;

   assign opcode    = ir_i[WIDTH-1 -: 4];
   assign ld_imm    = ir_i[27];
   assign wr_to_mem = ir_i[26];

   // Two's-complement magnitude. -2**(ADDRSIZE-1) maps to 2**(ADDRSIZE-1),
   // which still fits because the counter is treated as unsigned.
   assign rot_mag = rot_cnt_i[ADDRSIZE-1] ? (~rot_cnt_i + ADDRSIZE'(1)) : rot_cnt_i;

   assign unused_ir_bits = ^ir_i[25:0];

   // ------------------------------------------------------------------------
   // State register and registered memory-channel / status outputs.
   // Every transition back to FETCH loads mem_req_q from run_i: a FETCH
   // entered with run low keeps the request off and falls back to IDLE.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= S_IDLE;
         mem_req_q      <= 1'b0;
         mem_we_q       <= 1'b0;
         mem_addr_sel_q <= SEL_PC;
         rot_cnt_q      <= '0;
         rot_dir_q      <= 1'b0;
         halted_q       <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (run_i) begin
                  state_q        <= S_FETCH;
                  mem_req_q      <= 1'b1;
                  mem_we_q       <= 1'b0;
                  mem_addr_sel_q <= SEL_PC;
               end
            end

            S_FETCH: begin
               if (!mem_req_q) begin
                  state_q <= S_IDLE;
               end else if (mem.mem_ack) begin
                  state_q   <= S_DECODE;
                  mem_req_q <= 1'b0;
               end
            end

            S_DECODE: begin
               case (opcode)
                  OP_LD: begin
                     if (ld_imm) begin
                        state_q        <= S_FETCH;
                        mem_req_q      <= run_i;
                        mem_we_q       <= 1'b0;
                        mem_addr_sel_q <= SEL_PC;
                     end else begin
                        state_q        <= S_MEMOP;
                        mem_req_q      <= 1'b1;
                        mem_we_q       <= 1'b0;
                        mem_addr_sel_q <= SEL_SRC;
                     end
                  end
                  OP_STR: begin
                     state_q        <= S_MEMOP;
                     mem_req_q      <= 1'b1;
                     mem_we_q       <= 1'b1;
                     mem_addr_sel_q <= SEL_DST;
                  end
                  OP_ADD, OP_MUL, OP_CMP, OP_SHF: begin
                     state_q <= S_EXEC;
                  end
                  OP_ROT: begin
                     state_q   <= S_ROTATE;
                     rot_cnt_q <= rot_mag;
                     rot_dir_q <= rot_cnt_i[ADDRSIZE-1];
                  end
                  OP_HLT: begin
                     state_q  <= S_HALT;
                     halted_q <= 1'b1;
                  end
                  default: begin
                     // NOP, BRA and the undefined opcodes all refetch.
                     state_q        <= S_FETCH;
                     mem_req_q      <= run_i;
                     mem_we_q       <= 1'b0;
                     mem_addr_sel_q <= SEL_PC;
                  end
               endcase
            end

            S_EXEC: begin
               state_q <= S_WRITE;
            end

            S_ROTATE: begin
               if (rot_cnt_q != '0) begin
                  rot_cnt_q <= rot_cnt_q - ADDRSIZE'(1);
               end else begin
                  state_q <= S_WRITE;
               end
            end

            S_WRITE: begin
               if (wr_to_mem) begin
                  state_q        <= S_MEMOP;
                  mem_req_q      <= 1'b1;
                  mem_we_q       <= 1'b1;
                  mem_addr_sel_q <= SEL_DST;
               end else begin
                  state_q        <= S_FETCH;
                  mem_req_q      <= run_i;
                  mem_we_q       <= 1'b0;
                  mem_addr_sel_q <= SEL_PC;
               end
            end

            S_MEMOP: begin
               if (mem.mem_ack) begin
                  state_q        <= S_FETCH;
                  mem_req_q      <= run_i;
                  mem_we_q       <= 1'b0;
                  mem_addr_sel_q <= SEL_PC;
               end
            end

            S_HALT: begin
               state_q <= S_HALT;
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Single-cycle strobes, decoded from the registered state and inputs.
   // mem_ack only matters in FETCH (with a live request) and MEMOP.
   // ------------------------------------------------------------------------
   always_comb begin
      ir_load_o   = 1'b0;
      pc_inc_o    = 1'b0;
      pc_load_o   = 1'b0;
      alu_latch_o = 1'b0;
      rot_step_o  = 1'b0;
      rf_we_o     = 1'b0;
      psr_upd_o   = 1'b0;
      illegal_o   = 1'b0;

      case (state_q)
         S_FETCH: begin
            if (mem_req_q && mem.mem_ack) begin
               ir_load_o = 1'b1;
               pc_inc_o  = 1'b1;
            end
         end

         S_DECODE: begin
            case (opcode)
               OP_NOP: ;
               OP_BRA: pc_load_o = cond_true_i;
               OP_LD: begin
                  if (ld_imm) begin
                     rf_we_o   = 1'b1;
                     psr_upd_o = 1'b1;
                  end
               end
               OP_STR, OP_ADD, OP_MUL, OP_CMP, OP_SHF, OP_ROT, OP_HLT: ;
               default: illegal_o = 1'b1;
            endcase
         end

         S_EXEC: begin
            alu_latch_o = 1'b1;
         end

         S_ROTATE: begin
            rot_step_o = (rot_cnt_q != '0);
         end

         S_WRITE: begin
            // The memory-destination path updates PSR on the MEMOP ack.
            if (!wr_to_mem) begin
               rf_we_o   = 1'b1;
               psr_upd_o = 1'b1;
            end
         end

         S_MEMOP: begin
            if (mem.mem_ack) begin
               psr_upd_o = 1'b1;
               rf_we_o   = !mem_we_q;
            end
         end

         default: ;
      endcase
   end

   assign mem.mem_req      = mem_req_q;
   assign mem.mem_we       = mem_we_q;
   assign mem.mem_addr_sel = mem_addr_sel_q;

   assign rot_dir_o = rot_dir_q & (state_q == S_ROTATE);
   assign halted_o  = halted_q;
   assign state_o   = state_q;

endmodule

`default_nettype wire
